// File: rtl/key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : key_cmd_scheduler
// Purpose  : Turns N debounced, active-low key levels into short/long press
//            events. Each key owns a one-deep pending slot. Pending events are
//            issued one at a time over a valid/ready command port, and the
//            arbiter between keys is round-robin.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        synchronous active-low reset
//   key_n      in   N_KEYS   debounced key levels, 0 = pressed, idle 1
//   cmd_valid  out  1        command available
//   cmd_ready  in   1        consumer accepts when cmd_valid & cmd_ready
//   cmd_key    out  KEY_W    key index of the current command
//   cmd_long   out  1        1 = long press, 0 = short press
//   ovf_pulse  out  1        one-cycle pulse: an event was dropped because
//                            the key's pending slot was full
// ============================================================================
module key_cmd_scheduler #(
  parameter int N_KEYS   = 4,
  parameter int KEY_W    = 2,
  parameter int CNT_W    = 25,
  parameter int LONG_CYC = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [KEY_W-1:0]  cmd_key,
  output logic              cmd_long,
  output logic              ovf_pulse
);

  // The terminal count is the last cycle of a press that still counts as short.
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYC - 1);
  // At reset the pointer sits on the last key, so key 0 wins the first scan.
  localparam logic [KEY_W-1:0] c_PTR_RST   = KEY_W'(N_KEYS - 1);

  typedef enum logic [1:0] {
    ST_HELD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PRESS = 2'd2
  } key_state_e;

  // Events are produced in the cycle in which they are detected.
  logic [N_KEYS-1:0] w_ev_short;
  logic [N_KEYS-1:0] w_ev_long;
  logic [N_KEYS-1:0] w_ev_any;

  // Pending slots
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [N_KEYS-1:0] pend_long_q, pend_long_d;
  logic              ovf_d;

  // Arbiter and output register
  logic              cmd_valid_q;
  logic [KEY_W-1:0]  cmd_key_q;
  logic              cmd_long_q;
  logic              ovf_pulse_q;
  logic [KEY_W-1:0]  ptr_q;

  logic              w_out_free;
  logic              w_gnt_found;
  logic [KEY_W-1:0]  w_gnt_idx;
  logic [KEY_W:0]    w_scan_idx;
  logic [N_KEYS-1:0] w_grant;

  // --------------------------------------------------------------------------
  // Per-key press classifier
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    assign w_ev_short[gi] = (state_q == ST_PRESS) && key_n[gi];
    assign w_ev_long[gi]  = (state_q == ST_PRESS) && !key_n[gi] &&
                            (cnt_q == c_LONG_LAST);

    // HELD blocks all events until the key is seen released. Because reset
    // lands here, a key held through reset stays silent. It also makes the
    // release that follows a long press silent.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_HELD;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_HELD: begin
            if (key_n[gi]) state_q <= ST_IDLE;
          end
          ST_IDLE: begin
            if (!key_n[gi]) begin
              state_q <= ST_PRESS;
              cnt_q   <= '0;
            end
          end
          ST_PRESS: begin
            if (key_n[gi]) begin
              state_q <= ST_IDLE;
            end else if (cnt_q == c_LONG_LAST) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign w_ev_any = w_ev_short | w_ev_long;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: the first pending key after the pointer, with wrap.
  // The index is one bit wider than KEY_W so that ptr + N_KEYS cannot
  // overflow before it is reduced modulo N_KEYS.
  // --------------------------------------------------------------------------
  assign w_out_free = !cmd_valid_q || cmd_ready;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan_idx  = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      w_scan_idx = {1'b0, ptr_q} + (KEY_W+1)'(k);
      if (w_scan_idx >= (KEY_W+1)'(N_KEYS)) begin
        w_scan_idx = w_scan_idx - (KEY_W+1)'(N_KEYS);
      end
      if (!w_gnt_found && pend_q[w_scan_idx[KEY_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan_idx[KEY_W-1:0];
      end
    end
  end

  assign w_grant = (w_out_free && w_gnt_found) ? (N_KEYS'(1) << w_gnt_idx)
                                               : '0;

  // --------------------------------------------------------------------------
  // Pending slots. A key that is granted in this cycle frees its slot, so an
  // event arriving in the same cycle loads instead of overflowing.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    ovf_d       = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (w_grant[k]) pend_d[k] = 1'b0;
      if (w_ev_any[k]) begin
        if (pend_q[k] && !w_grant[k]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[k]      = 1'b1;
          pend_long_d[k] = w_ev_long[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_long_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output register. cmd_key and cmd_long only change when the register is
  // free, so they stay stable while the consumer stalls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_key_q   <= '0;
      cmd_long_q  <= 1'b0;
      ovf_pulse_q <= 1'b0;
      ptr_q       <= c_PTR_RST;
    end else begin
      ovf_pulse_q <= ovf_d;
      if (w_out_free) begin
        if (w_gnt_found) begin
          cmd_valid_q <= 1'b1;
          cmd_key_q   <= w_gnt_idx;
          cmd_long_q  <= pend_long_q[w_gnt_idx];
          ptr_q       <= w_gnt_idx;
        end else begin
          cmd_valid_q <= 1'b0;
        end
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_key   = cmd_key_q;
  assign cmd_long  = cmd_long_q;
  assign ovf_pulse = ovf_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_cmd_scheduler
// Purpose  : Self-checking bench for key_cmd_scheduler (N_KEYS=4,
//            LONG_CYC=8). A reference model predicts the issued commands
//            into a scoreboard queue, and a monitor pops and compares the
//            queue on every handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_cmd_scheduler;

  localparam int N_KEYS   = 4;
  localparam int KEY_W    = 2;
  localparam int CNT_W    = 4;
  localparam int LONG_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_KEYS-1:0] key_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [KEY_W-1:0]  cmd_key;
  logic              cmd_long;
  logic              ovf_pulse;

  key_cmd_scheduler #(
    .N_KEYS   (N_KEYS),
    .KEY_W    (KEY_W),
    .CNT_W    (CNT_W),
    .LONG_CYC (LONG_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_long  (cmd_long),
    .ovf_pulse (ovf_pulse)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int hs_count  = 0;
  int ovf_count = 0;

  // Scoreboard: each entry is {key, long}.
  logic [KEY_W:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. A press is a run of low samples on an armed key. The run
  // becomes long on its (LONG_CYC+1)-th low sample, and is short if it ends
  // earlier. Keys are disarmed after reset and after a long press until they
  // are seen high. Pending slots hold one event per key, and grants go to the
  // next pending key after the last granted one.
  // --------------------------------------------------------------------------
  int m_low   [N_KEYS];
  bit m_armed [N_KEYS];
  bit m_pend  [N_KEYS];
  bit m_plong [N_KEYS];
  bit m_valid = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_init  = 1'b0;
  int m_ptr   = N_KEYS - 1;

  task automatic model_step();
    bit ev  [N_KEYS];
    bit evl [N_KEYS];
    bit free, found, out_long, ovf;
    int g, c;
    if (!rst_n) begin
      for (int k = 0; k < N_KEYS; k++) begin
        m_low[k] = 0; m_armed[k] = 0; m_pend[k] = 0; m_plong[k] = 0;
      end
      m_valid = 0; m_ovf = 0; m_ptr = N_KEYS - 1; m_init = 1;
      exp_q.delete();
      return;
    end
    for (int k = 0; k < N_KEYS; k++) begin
      ev[k] = 0; evl[k] = 0;
      if (!m_armed[k]) begin
        if (key_n[k]) m_armed[k] = 1;
      end else if (!key_n[k]) begin
        m_low[k]++;
        if (m_low[k] == LONG_CYC + 1) begin
          ev[k] = 1; evl[k] = 1; m_armed[k] = 0; m_low[k] = 0;
        end
      end else begin
        if (m_low[k] > 0) ev[k] = 1;
        m_low[k] = 0;
      end
    end
    free  = !m_valid || cmd_ready;
    found = 0; g = 0; out_long = 0;
    if (free) begin
      for (int d = 1; d <= N_KEYS; d++) begin
        c = (m_ptr + d) % N_KEYS;
        if (!found && m_pend[c]) begin found = 1; g = c; end
      end
    end
    if (found) begin
      out_long = m_plong[g];
      m_pend[g] = 0;
    end
    ovf = 0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (ev[k]) begin
        if (m_pend[k]) ovf = 1;
        else begin m_pend[k] = 1; m_plong[k] = evl[k]; end
      end
    end
    if (free) begin
      if (found) begin
        m_valid = 1;
        m_ptr   = g;
        exp_q.push_back({KEY_W'(g), out_long});
      end else begin
        m_valid = 0;
      end
    end
    m_ovf = ovf;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: sampled on the falling edge, while the inputs for the next
  // rising edge are already stable.
  // --------------------------------------------------------------------------
  initial begin
    bit             prev_stall;
    logic [KEY_W-1:0] prev_key;
    logic           prev_long;
    logic [KEY_W:0] e;
    prev_stall = 0;
    prev_key   = '0;
    prev_long  = 0;
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        chk("ovf_pulse", 32'(ovf_pulse), 32'(m_ovf));
        if (ovf_pulse === 1'b1) ovf_count++;
        if (prev_stall) begin
          chk("hold_key",  32'(cmd_key),  32'(prev_key));
          chk("hold_long", 32'(cmd_long), 32'(prev_long));
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && rst_n === 1'b1) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected: got key %0d long %0d, required no command at %0t",
                     cmd_key, cmd_long, $time);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_key",  32'(cmd_key),  32'(e[KEY_W:1]));
            chk("cmd_long", 32'(cmd_long), 32'(e[0]));
          end
        end
        prev_stall = (cmd_valid === 1'b1) && (cmd_ready !== 1'b1) && (rst_n === 1'b1);
        prev_key   = cmd_key;
        prev_long  = cmd_long;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_phase(input int cycles);
    int run [N_KEYS];
    int pct;
    pct = 100;
    for (int k = 0; k < N_KEYS; k++) run[k] = $urandom_range(0, 5);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 100;
          1:       pct = 60;
          default: pct = 10;
        endcase
      end
      cmd_ready = ($urandom_range(0, 99) < pct);
      for (int k = 0; k < N_KEYS; k++) begin
        if (run[k] == 0) begin
          key_n[k] = ~key_n[k];
          run[k] = key_n[k] ? $urandom_range(1, 6) : $urandom_range(1, 12);
        end else begin
          run[k]--;
        end
      end
      tick();
    end
  endtask

  initial begin
    int hs0, ov0;
    rst_n     = 1'b0;
    key_n     = 4'b1110;
    cmd_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(cmd_valid), 32'(0));
    chk("rst_key",   32'(cmd_key),   32'(0));
    chk("rst_long",  32'(cmd_long),  32'(0));
    chk("rst_ovf",   32'(ovf_pulse), 32'(0));
    rst_n = 1'b1;

    // 1: key0 held through reset is silent
    hs0 = hs_count; ov0 = ovf_count;
    tick(5);
    key_n[0] = 1'b1;
    tick(4);
    chk("t1_no_cmd", 32'(hs_count - hs0), 32'(0));
    chk("t1_no_ovf", 32'(ovf_count - ov0), 32'(0));

    // 2: short press on key1
    hs0 = hs_count;
    key_n[1] = 1'b0; tick(3);
    key_n[1] = 1'b1; tick(6);
    chk("t2_cmds", 32'(hs_count - hs0), 32'(1));

    // 3: long press on key2, release is silent
    hs0 = hs_count;
    key_n[2] = 1'b0; tick(20);
    key_n[2] = 1'b1; tick(6);
    chk("t3_cmds", 32'(hs_count - hs0), 32'(1));

    // 4: simultaneous releases on keys 0,1,3, then key0 again
    hs0 = hs_count;
    key_n = 4'b0100; tick(3);
    key_n = 4'b1111; tick(1);
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(8);
    chk("t4_cmds", 32'(hs_count - hs0), 32'(4));

    // 5: stalled consumer, three short presses on key0
    hs0 = hs_count; ov0 = ovf_count;
    cmd_ready = 1'b0;
    repeat (3) begin
      key_n[0] = 1'b0; tick(2);
      key_n[0] = 1'b1; tick(2);
    end
    tick(4);
    cmd_ready = 1'b1;
    tick(6);
    chk("t5_cmds", 32'(hs_count - hs0), 32'(2));
    chk("t5_ovf",  32'(ovf_count - ov0), 32'(1));

    // 6: key3 long event lands in the cycle its pending short is granted
    hs0 = hs_count; ov0 = ovf_count;
    cmd_ready = 1'b0;
    key_n[1] = 1'b0; tick(2);
    key_n[1] = 1'b1; tick(2);
    key_n[3] = 1'b0; tick(2);
    key_n[3] = 1'b1; tick(2);
    key_n[3] = 1'b0; tick(8);
    cmd_ready = 1'b1; tick(6);
    key_n[3] = 1'b1; tick(4);
    chk("t6_cmds", 32'(hs_count - hs0), 32'(3));
    chk("t6_ovf",  32'(ovf_count - ov0), 32'(0));

    // Random traffic, a mid-run reset with keys in random states, more traffic
    random_phase(3000);
    rst_n = 1'b0;
    key_n = 4'($urandom_range(0, 15));
    tick(2);
    rst_n = 1'b1;
    random_phase(800);

    // Drain
    key_n     = '1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 60 && !(exp_q.size() == 0 && cmd_valid === 1'b0); i++) tick();
    chk("drain_queue", 32'(exp_q.size()), 32'(0));
    chk("drain_valid", 32'(cmd_valid), 32'(0));
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
